term_packer: RTL and testbench
==============================

TERM_PACKER -- requirements
Module: term_packer

Interface
- REQ-001: The block SHALL have parameter NUM_ELEMENTS, default 9, giving the number of terms per frame (minimum 2).
- REQ-002: The block SHALL have parameter WORD_LEN, default 16, giving the width of each input word.
- REQ-003: The block SHALL have parameter BIT_LEN, default 20, giving the width of each output term; BIT_LEN >= WORD_LEN + $clog2(NUM_ELEMENTS) SHALL be checked at elaboration.
- REQ-004: Port clk, input, 1 bit: the only clock; all logic is on the rising edge.
- REQ-005: Port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006: Port in_valid, input, 1 bit: in_word is valid.
- REQ-007: Port in_ready, output, 1 bit: the block can accept a word.
- REQ-008: Port in_word, input, WORD_LEN bits: raw term.
- REQ-009: Port in_last, input, 1 bit: the word is the final word of a frame (allows an early close).
- REQ-010: Port out_valid, output, 1 bit: the frame is complete and stable.
- REQ-011: Port out_ready, input, 1 bit: the downstream summer accepts the frame.
- REQ-012: Port terms, output, unpacked array [NUM_ELEMENTS] of BIT_LEN bits: the extended terms.
- REQ-013: Port out_count, output, $clog2(NUM_ELEMENTS+1) bits: the number of valid terms in the frame.

Function
- REQ-014: An input word SHALL be accepted on any cycle where in_valid and in_ready are both 1.
- REQ-015: The block SHALL have two states: FILL (collecting; out_valid=0) and HOLD (frame presented; out_valid=1).
- REQ-016: In FILL, the k-th accepted word (k from 0) SHALL be stored in terms[k], extended to BIT_LEN bits, and the write index SHALL increment.
- REQ-017: FILL SHALL go to HOLD on the cycle after accepting word index NUM_ELEMENTS-1, or after accepting any word with in_last=1.
- REQ-018: On an early close, terms[k..NUM_ELEMENTS-1] SHALL read 0, so that a summer of all terms gives the sum of the valid words only.
- REQ-019: out_count SHALL equal the number of words accepted into the frame (1..NUM_ELEMENTS) while out_valid=1, and SHALL be 0 otherwise.
- REQ-020: In HOLD, terms and out_count SHALL stay stable until out_valid and out_ready are both 1.
- REQ-021: in_ready SHALL be 1 in FILL; in HOLD it SHALL equal out_ready (same-cycle pass-through ready).
- REQ-022: If a frame is released and a word is accepted on the same cycle, that word SHALL become terms[0] of the next frame; all other slots SHALL clear to 0; out_count SHALL become 0; and the state SHALL be FILL with index 1.
- REQ-023: That same-cycle word SHALL move straight back to HOLD if NUM_ELEMENTS=1 is ruled out and in_last=1, as a one-term frame.
- REQ-024: When a frame is released with no word accepted, the state SHALL go to FILL with index 0 and all slots cleared to 0.
- REQ-025: The write index SHALL never wrap past NUM_ELEMENTS-1; words are only accepted in FILL or on the release cycle.
- REQ-026: in_valid=1 with in_ready=0 SHALL have no effect; the upstream holds its word.
- REQ-027: The latency from the last accepted word to out_valid=1 SHALL be 1 cycle.
- REQ-028: out_valid SHALL NOT depend on out_ready combinationally.

Reset
- REQ-029: While rst_n=0 at a clock edge, the block SHALL enter FILL with index 0, out_valid=0, out_count=0 and all terms=0; in_ready SHALL be 1 after reset.
- REQ-030: Reset in mid-frame or in HOLD SHALL discard the partial or held frame without emitting it.

Configuration
- REQ-031: With macro TERM_PACKER_SIGN_EXT_EN defined, words SHALL be sign-extended (replicated MSB) to BIT_LEN bits.
- REQ-032: Without TERM_PACKER_SIGN_EXT_EN, words SHALL be zero-extended to BIT_LEN bits.
- REQ-033: Padding slots from an early close SHALL be 0 in both builds.

Verification
- REQ-034: Defaults; stream words 1..9, out_ready=1 -> out_valid=1 one cycle after the 9th word; terms[i]=i+1; out_count=9; all-terms sum 45.
- REQ-035: Words 5, 7, 3 with in_last on 3 -> terms={5,7,3,0,0,0,0,0,0}; out_count=3; sum 15.
- REQ-036: Frame held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0; terms unchanged; no word lost; release cycle accepts the next word into terms[0].
- REQ-037: Word 16'hFFFF x9 -> zero-extended build: sum 20'h8FFF7; with TERM_PACKER_SIGN_EXT_EN: each term 20'hFFFFF.
- REQ-038: rst_n=0 for one cycle after 4 words -> out_valid=0, index 0; the next frame starts at terms[0].

Source files
------------

// File: rtl/term_packer.sv
// term_packer: collects up to NUM_ELEMENTS input words into a frame of
// BIT_LEN-wide terms for a downstream summer. It fills the frame, then holds
// it until the summer accepts it.
//
// Build option: define TERM_PACKER_SIGN_EXT_EN to sign-extend words. When it
// is not defined, words are zero-extended. Padding slots left by an early
// close are always 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never waits on ready. A source that raises valid holds its
// data stable until the transfer happens.
//   - Input side: in_valid/in_ready carry in_word and in_last.
//   - Output side: out_valid/out_ready carry terms and out_count.
//   - out_valid is a pure register output.
//   - in_ready passes out_ready straight through while a frame is held. This
//     lets the release cycle also take the first word of the next frame.
module term_packer #(
  parameter int NUM_ELEMENTS = 9,
  parameter int WORD_LEN     = 16,
  parameter int BIT_LEN      = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_LEN-1:0]               in_word,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_LEN-1:0]                terms [NUM_ELEMENTS],
  output logic [$clog2(NUM_ELEMENTS+1)-1:0] out_count,
  output logic                              state_dbg_o
);

  localparam int CNT_W = $clog2(NUM_ELEMENTS + 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Reject configurations where a full frame of words could overflow a term.
  if (NUM_ELEMENTS < 2) begin : g_chk_num
    $error("term_packer: NUM_ELEMENTS must be at least 2");
  end
  if (BIT_LEN < WORD_LEN + $clog2(NUM_ELEMENTS)) begin : g_chk_width
    $error("term_packer: BIT_LEN must be >= WORD_LEN + clog2(NUM_ELEMENTS)");
  end

  // Widen one raw word to a term.
  function automatic logic [BIT_LEN-1:0] extend(input logic [WORD_LEN-1:0] w);
`ifdef TERM_PACKER_SIGN_EXT_EN
    return BIT_LEN'($signed(w));
`else
    return BIT_LEN'(w);
`endif
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BIT_LEN-1:0]   terms_q [NUM_ELEMENTS];
  logic [BIT_LEN-1:0]   terms_d [NUM_ELEMENTS];

  logic                 take;
  logic                 last_slot;
  logic [BIT_LEN-1:0]   word_ext;

  assign take      = in_valid && in_ready;
  assign last_slot = (count_q == CNT_W'(NUM_ELEMENTS - 1));
  assign word_ext  = extend(in_word);

  // Handshake and frame outputs, all derived from registered state.
  assign in_ready    = (state_q == FILL) || out_ready;
  assign out_valid   = (state_q == HOLD);
  assign out_count   = out_valid ? count_q : '0;
  assign terms       = terms_q;
  assign state_dbg_o = state_q;

  // Next-state logic: fill slots in order, hold the frame, and clear it on release.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    terms_d = terms_q;
    case (state_q)
      FILL: begin
        if (take) begin
          // count_q doubles as the write index and stays below NUM_ELEMENTS here.
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (count_q == CNT_W'(i)) begin
              terms_d[i] = word_ext;
            end
          end
          count_d = count_q + CNT_W'(1);
          if (in_last || last_slot) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          // Clear every slot so that an early close in the next frame pads with 0.
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            terms_d[i] = '0;
          end
          count_d = '0;
          state_d = FILL;
          if (take) begin
            // A word taken on the release cycle opens the next frame.
            terms_d[0] = word_ext;
            count_d    = CNT_W'(1);
            if (in_last) begin
              state_d = HOLD;
            end
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register. Reset drops any partial or held frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        terms_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        terms_q[i] <= terms_d[i];
      end
    end
  end

  // A frame that is presented but not yet accepted stays presented and unchanged.
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_count)));

  // The write index never runs past the frame.
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(NUM_ELEMENTS));

endmodule

// File: tb/tb_term_packer.sv
// Testbench for term_packer. It uses a table of frames plus hand-written
// sequences for back-pressure and reset, and checks each released frame
// against an expected queue.
module tb_term_packer;

  localparam int N  = 9;
  localparam int WL = 16;
  localparam int BL = 20;
  localparam int CW = $clog2(N + 1);
  localparam int FW = CW + N * BL;

  typedef logic [FW-1:0] frame_t;

  typedef struct {
    int              n;
    logic            last;
    logic [WL-1:0]   w [N];
    logic [BL-1:0]   sum;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [WL-1:0]   in_word;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BL-1:0]   terms [N];
  logic [CW-1:0]   out_count;
  logic            state_dbg;

  int              checks = 0;
  int              passed = 0;
  frame_t          exp_q [$];
  logic [BL-1:0]   exp_sum_q [$];
  frame_t          mon_e;
  logic [BL-1:0]   mon_s;
  vec_t            vecs [8];

  term_packer #(
    .NUM_ELEMENTS(N),
    .WORD_LEN    (WL),
    .BIT_LEN     (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .terms      (terms),
    .out_count  (out_count),
    .state_dbg_o(state_dbg)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so that a stuck run still ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [BL-1:0] ext(input logic [WL-1:0] w);
`ifdef TERM_PACKER_SIGN_EXT_EN
    return {{(BL-WL){w[WL-1]}}, w};
`else
    return {{(BL-WL){1'b0}}, w};
`endif
  endfunction

  function automatic frame_t dut_frame();
    frame_t f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*BL +: BL] = terms[i];
    f[N*BL +: CW] = out_count;
    return f;
  endfunction

  function automatic logic [BL-1:0] dut_sum();
    logic [BL-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + terms[i];
    return s;
  endfunction

  function automatic frame_t model_frame(input vec_t v);
    frame_t f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*BL +: BL] = (i < v.n) ? ext(v.w[i]) : '0;
    f[N*BL +: CW] = CW'(v.n);
    return f;
  endfunction

  task automatic expect_vec(input vec_t v);
    exp_q.push_back(model_frame(v));
    exp_sum_q.push_back(v.sum);
  endtask

  // Drive one word and wait, up to a bounded number of cycles, for it to be taken.
  task automatic send(input logic [WL-1:0] w, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for word %0h", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      send(v.w[i], (i == v.n - 1) ? v.last : 1'b0);
      if (i < v.n - 1) begin
        check("fill_out_valid", out_valid, 1'b0);
      end else begin
        check("latency_out_valid", out_valid, 1'b1);
        check("latency_out_count", out_count, v.n);
      end
    end
  endtask

  // Scoreboard: compare each frame as it is handed to the summer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_frame: got %h expected none", dut_frame());
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = exp_sum_q.pop_front();
        checks++;
        if (dut_frame() === mon_e) passed++;
        else $display("FAIL frame: got %h expected %h", dut_frame(), mon_e);
        check("frame_sum", dut_sum(), mon_s);
      end
    end
  end

  initial begin
    vec_t hv;
    vec_t hv2;
    vec_t rv;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Frame table: n words, in_last flag on the final word, and expected sum.
    for (int k = 0; k < 8; k++) begin
      vecs[k].n    = 0;
      vecs[k].last = 1'b0;
      vecs[k].sum  = '0;
      for (int i = 0; i < N; i++) vecs[k].w[i] = '0;
    end
    vecs[0].n = 9; vecs[0].last = 1'b0; vecs[0].sum = 20'd45;
    for (int i = 0; i < 9; i++) vecs[0].w[i] = WL'(i + 1);
    vecs[1].n = 3; vecs[1].last = 1'b1; vecs[1].sum = 20'd15;
    vecs[1].w[0] = 16'd5; vecs[1].w[1] = 16'd7; vecs[1].w[2] = 16'd3;
    vecs[2].n = 9; vecs[2].last = 1'b0;
    for (int i = 0; i < 9; i++) vecs[2].w[i] = 16'hFFFF;
`ifdef TERM_PACKER_SIGN_EXT_EN
    vecs[2].sum = 20'hFFFF7;
`else
    vecs[2].sum = 20'h8FFF7;
`endif
    vecs[3].n = 1; vecs[3].last = 1'b1; vecs[3].sum = 20'h01234;
    vecs[3].w[0] = 16'h1234;
    vecs[4].n = 8; vecs[4].last = 1'b1; vecs[4].sum = 20'd360;
    for (int i = 0; i < 8; i++) vecs[4].w[i] = WL'(10 * (i + 1));
    vecs[5].n = 9; vecs[5].last = 1'b1; vecs[5].sum = 20'd4500;
    for (int i = 0; i < 9; i++) vecs[5].w[i] = WL'(100 * (i + 1));
    for (int k = 6; k < 8; k++) begin
      vecs[k].n    = int'($urandom_range(1, N));
      vecs[k].last = (vecs[k].n < N) ? 1'b1 : 1'($urandom_range(0, 1));
      vecs[k].sum  = '0;
      for (int i = 0; i < vecs[k].n; i++) begin
        vecs[k].w[i] = WL'($urandom_range(0, 65535));
        vecs[k].sum  = vecs[k].sum + ext(vecs[k].w[i]);
      end
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_count", out_count, 0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_state", state_dbg, 1'b0);
    check("reset_terms_zero", dut_frame() == '0, 1'b1);
    rst_n = 1'b1;

    // Streaming frames back to back with the summer always ready.
    for (int k = 0; k < 8; k++) begin
      expect_vec(vecs[k]);
      send_vec(vecs[k]);
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: hold a frame for 5 cycles while the next word waits.
    out_ready = 1'b0;
    hv.n = 3; hv.last = 1'b1; hv.sum = 20'd36;
    for (int i = 0; i < N; i++) hv.w[i] = '0;
    hv.w[0] = 16'd11; hv.w[1] = 16'd12; hv.w[2] = 16'd13;
    expect_vec(hv);
    send(16'd11, 1'b0);
    send(16'd12, 1'b0);
    send(16'd13, 1'b1);
    check("hold_enter_valid", out_valid, 1'b1);
    in_valid = 1'b1;
    in_word  = 16'h0077;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_count", out_count, 3);
      check("hold_frame_stable", dut_frame() == model_frame(hv), 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_out_valid", out_valid, 1'b0);
    check("release_out_count", out_count, 0);
    check("release_term0", terms[0], ext(16'h0077));
    check("release_term1", terms[1], 0);
    hv2.n = 2; hv2.last = 1'b1; hv2.sum = 20'h000FF;
    for (int i = 0; i < N; i++) hv2.w[i] = '0;
    hv2.w[0] = 16'h0077; hv2.w[1] = 16'h0088;
    expect_vec(hv2);
    send(16'h0088, 1'b1);
    check("second_frame_valid", out_valid, 1'b1);
    check("second_frame_count", out_count, 2);
    repeat (2) @(posedge clk);
    #1;

    // Reset part-way through a frame, after four words.
    send(16'h0021, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0023, 1'b0);
    send(16'h0024, 1'b0);
    check("partial_out_valid", out_valid, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_count", out_count, 0);
    check("midrst_state", state_dbg, 1'b0);
    check("midrst_terms_zero", dut_frame() == '0, 1'b1);
    check("midrst_in_ready", in_ready, 1'b1);
    rv.n = 2; rv.last = 1'b1; rv.sum = 20'h00143;
    for (int i = 0; i < N; i++) rv.w[i] = '0;
    rv.w[0] = 16'h00A1; rv.w[1] = 16'h00A2;
    expect_vec(rv);
    send(16'h00A1, 1'b0);
    send(16'h00A2, 1'b1);
    check("midrst_next_term0", terms[0], ext(16'h00A1));
    check("midrst_next_count", out_count, 2);
    @(posedge clk);
    #1;

    // Reset while a frame is held: the frame must never be handed over.
    out_ready = 1'b0;
    send(16'h0031, 1'b0);
    send(16'h0032, 1'b1);
    check("hold_before_rst", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("holdrst_out_valid", out_valid, 1'b0);
    check("holdrst_terms_zero", dut_frame() == '0, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_expected_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
